// File: rtl/ifetch_responder.sv
// Instruction-fetch responder: serves 32-bit words from a loadable program store to a core.
// Latency: instr_valid pulses in the cycle after edge N+1+LATENCY, where N is the accept edge.
// Backpressure: fetch_ready is high only in IDLE; requests outside IDLE are dropped, never queued.
// Optional feature: define IFETCH_HALT_DETECT_EN to stop fetching once HALT_WORD is delivered.
module ifetch_responder #(
    parameter int          DEPTH     = 512,
    parameter int          LATENCY   = 1,
    parameter logic [31:0] HALT_WORD = 32'h0000007f,
    parameter logic [31:0] NOP_WORD  = 32'h00000013
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [10:0] fetch_pc,
    output logic        fetch_ready,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        misalign,
    output logic        halted,
    input  logic        prog_we,
    input  logic [8:0]  prog_addr,
    input  logic [31:0] prog_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;

    // Wait-counter preload; only used when LATENCY is non-zero.
    localparam logic [1:0] LAT_M1 = (LATENCY > 0) ? 2'(LATENCY - 1) : 2'd0;

`ifdef IFETCH_HALT_DETECT_EN
    localparam logic HALT_EN = 1'b1;
`else
    localparam logic HALT_EN = 1'b0;
`endif

    logic [31:0] mem [DEPTH];
    logic [1:0]  state;
    logic [1:0]  wait_cnt;
    logic [10:0] latched_pc;
    logic        rd_mis;
    logic [31:0] rd_word;

    // Program store write port; deliberately untouched by reset so a reset keeps the program.
    always_ff @(posedge CLOCK_50) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // Word to deliver from the latched PC; misaligned fetches get a NOP instead of memory data.
    always_comb begin
        rd_mis  = (latched_pc[1:0] != 2'b00);
        rd_word = rd_mis ? NOP_WORD : mem[latched_pc[10:2]];
    end

    // Fetch FSM; the response edge reads the store before any same-edge write lands.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            wait_cnt    <= 2'd0;
            latched_pc  <= 11'd0;
            instr       <= 32'd0;
            instr_valid <= 1'b0;
            misalign    <= 1'b0;
            halted      <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            misalign    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fetch_req) begin
                        latched_pc <= fetch_pc;
                        if (LATENCY == 0) begin
                            state <= S_RESP;
                        end else begin
                            state    <= S_WAIT;
                            wait_cnt <= LAT_M1;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        state <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                S_RESP: begin
                    instr       <= rd_word;
                    instr_valid <= 1'b1;
                    misalign    <= rd_mis;
                    if (HALT_EN && (rd_word == HALT_WORD)) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign fetch_ready = (state == S_IDLE);

endmodule

// File: tb/tb_ifetch_responder.sv
// Bench for ifetch_responder: three instances (LATENCY 0, 1, 3) share clock, reset and load bus.
// Expected responses are queued at issue time and checked by an independent negedge monitor.
// Each instance has its own fetch_req; only one instance is exercised at a time.
module tb_ifetch_responder;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       req;
    logic [10:0]      pc;
    logic             pwe;
    logic [8:0]       paddr;
    logic [31:0]      pdata;
    logic [2:0]       rdy, vld, mis, hlt;
    logic [2:0][31:0] ins;
    logic [2:0][31:0] last;

    typedef struct {
        int          d;
        logic [31:0] w;
        logic        m;
        int          at;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

`ifdef IFETCH_HALT_DETECT_EN
    localparam logic HALT_EXP = 1'b1;
`else
    localparam logic HALT_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    // Edge counter: at a negedge, cyc is the index of the rising edge just taken.
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ifetch_responder #(.LATENCY(g == 0 ? 0 : (g == 1 ? 1 : 3))) u_dut (
            .CLOCK_50   (clk),
            .reset      (rst),
            .fetch_req  (req[g]),
            .fetch_pc   (pc),
            .fetch_ready(rdy[g]),
            .instr      (ins[g]),
            .instr_valid(vld[g]),
            .misalign   (mis[g]),
            .halted     (hlt[g]),
            .prog_we    (pwe),
            .prog_addr  (paddr),
            .prog_data  (pdata)
        );
    end

    function automatic int lat(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at edge %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: every valid pulse must match the head of the queue, including its edge.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                last[d] = 32'd0;
            end else if (vld[d]) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: dut %0d instr %h at edge %0d", d, ins[d], cyc);
                end else begin
                    e_mon = q.pop_front();
                    check("resp_dut", d, e_mon.d);
                    check("instr", ins[d], e_mon.w);
                    check("misalign", {31'd0, mis[d]}, {31'd0, e_mon.m});
                    check("valid_edge", cyc, e_mon.at);
                end
                last[d] = ins[d];
            end else begin
                check("instr_hold", ins[d], last[d]);
                check("misalign_idle", {31'd0, mis[d]}, 32'd0);
            end
        end
    end

    // Issue one fetch at a negedge; returns at the negedge after the accept edge.
    task automatic fetch(input int d, input logic [10:0] a, input logic [31:0] w, input logic m);
        int n;
        check("ready_before_req", {31'd0, rdy[d]}, 32'd1);
        pc     = a;
        req[d] = 1'b1;
        @(negedge clk);
        n      = cyc;
        req[d] = 1'b0;
        q.push_back('{d, w, m, n + 1 + lat(d)});
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL response_timeout: %0d responses missing", q.size());
            q.delete();
        end
    endtask

    task automatic load(input logic [8:0] a, input logic [31:0] w);
        pwe   = 1'b1;
        paddr = a;
        pdata = w;
        @(negedge clk);
        pwe   = 1'b0;
    endtask

    // Hold a request high for two accepts; the second must land LATENCY+2 edges after the first.
    task automatic back_to_back(input int d, input logic [10:0] a, input logic [31:0] w);
        int n;
        check("ready_b2b", {31'd0, rdy[d]}, 32'd1);
        pc     = a;
        req[d] = 1'b1;
        @(negedge clk);
        n = cyc;
        q.push_back('{d, w, 1'b0, n + 1 + lat(d)});
        repeat (lat(d) + 2) @(negedge clk);
        req[d] = 1'b0;
        q.push_back('{d, w, 1'b0, n + lat(d) + 2 + 1 + lat(d)});
        wait_idle();
    endtask

    initial begin
        rst   = 1'b1;
        req   = 3'b000;
        pc    = 11'd0;
        pwe   = 1'b0;
        paddr = 9'd0;
        pdata = 32'd0;
        repeat (2) @(negedge clk);

        // Reset values on every instance.
        for (int d = 0; d < 3; d++) begin
            check("rst_ready", {31'd0, rdy[d]}, 32'd1);
            check("rst_valid", {31'd0, vld[d]}, 32'd0);
            check("rst_instr", ins[d], 32'd0);
            check("rst_misalign", {31'd0, mis[d]}, 32'd0);
            check("rst_halted", {31'd0, hlt[d]}, 32'd0);
        end

        // Program load works while reset is held.
        load(9'd0, 32'h00500293);
        load(9'd1, 32'h00500293);
        load(9'd2, 32'h00c000ef);
        load(9'd10, 32'h0000007f);
        #2 rst = 1'b0;
        @(negedge clk);

        // LATENCY=1 fetch of 0x008: busy after accept, ready again after N+3.
        fetch(1, 11'h008, 32'h00c000ef, 1'b0);
        check("ready_in_wait", {31'd0, rdy[1]}, 32'd0);
        repeat (3) @(negedge clk);
        check("ready_after_n3", {31'd0, rdy[1]}, 32'd1);
        wait_idle();

        // LATENCY 0 and 3 on 0x004.
        fetch(0, 11'h004, 32'h00500293, 1'b0);
        wait_idle();
        fetch(2, 11'h004, 32'h00500293, 1'b0);
        wait_idle();

        // Misaligned fetch returns NOP, not word 0.
        fetch(1, 11'h003, 32'h00000013, 1'b1);
        wait_idle();
        fetch(0, 11'h002, 32'h00000013, 1'b1);
        wait_idle();

        // Back-to-back throughput.
        back_to_back(0, 11'h004, 32'h00500293);
        back_to_back(1, 11'h008, 32'h00c000ef);

        // Reset in the middle of a LATENCY=3 wait drops the fetch.
        pc     = 11'h008;
        req[2] = 1'b1;
        @(negedge clk);
        req[2] = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midwait_rst_ready", {31'd0, rdy[2]}, 32'd1);
        check("midwait_rst_valid", {31'd0, vld[2]}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (6) @(negedge clk);
        fetch(2, 11'h008, 32'h00c000ef, 1'b0);
        wait_idle();

        // Write on the response edge: old word returned, new word on the next fetch.
        fetch(1, 11'h008, 32'h00c000ef, 1'b0);
        @(negedge clk);
        pwe   = 1'b1;
        paddr = 9'd2;
        pdata = 32'hdeadbeef;
        @(negedge clk);
        pwe   = 1'b0;
        wait_idle();
        fetch(1, 11'h008, 32'hdeadbeef, 1'b0);
        wait_idle();

        // Halt word delivery.
        fetch(1, 11'h028, 32'h0000007f, 1'b0);
        repeat (2) @(negedge clk);
        check("halted_on_valid", {31'd0, hlt[1]}, {31'd0, HALT_EXP});
        wait_idle();
        if (HALT_EXP) begin
            pc     = 11'h004;
            req[1] = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                check("halt_ready_low", {31'd0, rdy[1]}, 32'd0);
                check("halt_sticky", {31'd0, hlt[1]}, 32'd1);
            end
            req[1] = 1'b0;
            #2 rst = 1'b1;
            @(negedge clk);
            #2 rst = 1'b0;
            @(negedge clk);
            check("halt_cleared", {31'd0, hlt[1]}, 32'd0);
            check("halt_ready_back", {31'd0, rdy[1]}, 32'd1);
        end else begin
            fetch(1, 11'h004, 32'h00500293, 1'b0);
            wait_idle();
            check("halted_stays_0", {31'd0, hlt[1]}, 32'd0);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
